rr_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the 3-bit, 4-input bus mux between three requesters (A, B, C).
- Owns the mux select: grant 0/1/2 drives sel 2'b00/2'b01/2'b10.
- When nothing is granted it parks the bus at sel 2'b11, so the mux outputs high-Z.
- Enforces a maximum tenure per grant so that no requester can starve the others.

---
 rtl/rr_bus_arbiter_if.sv | 11 +
 rtl/rr_bus_arbiter.sv | 96 +++++++++
 tb/tb_rr_bus_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between three bus requesters and the round-robin mux arbiter.
interface rr_bus_arbiter_if;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (output req, input grant, sel, busy, timeout);
  modport slave  (input req, output grant, sel, busy, timeout);
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin owner of the 3-requester bus mux select; grant follows req by one cycle, all outputs registered.
// No backpressure path: an owner keeps the bus at most MAX_HOLD cycles, then is handed off (timeout pulse).
module rr_bus_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  rr_bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           state;
  logic [1:0]       last;
  logic [CNT_W-1:0] count;
  logic [2:0]       rot_req;
  logic [1:0]       ord0, ord1, ord2;
  logic [1:0]       pick;
  logic             pick_vld;
  logic             own_req;
  logic             forced;
  logic             release_now;

  // Search order starts just after the last owner, so the last owner is tried last.
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    unique case (last)
      2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
  end

  always_comb begin
    rot_req = {bus.req[2], bus.req[1], bus.req[0]};
    unique case (last)
      2'd0:    rot_req = {bus.req[0], bus.req[2], bus.req[1]};
      2'd1:    rot_req = {bus.req[1], bus.req[0], bus.req[2]};
      default: rot_req = {bus.req[2], bus.req[1], bus.req[0]};
    endcase
  end

  always_comb begin
    pick     = ord0;
    pick_vld = 1'b1;
    if (rot_req[0])      pick = ord0;
    else if (rot_req[1]) pick = ord1;
    else if (rot_req[2]) pick = ord2;
    else                 pick_vld = 1'b0;
  end

  assign own_req     = |(bus.req & bus.grant);
  assign forced      = (state == OWN) && (count == HOLD_MAX);
  assign release_now = (state == OWN) && (!own_req || count == HOLD_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 2'd2;
      count       <= '0;
      bus.grant   <= 3'b000;
      bus.sel     <= 2'b11;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= forced;
      if (state == IDLE || release_now) begin
        if (pick_vld) begin
          state     <= OWN;
          last      <= pick;
          count     <= CNT_W'(1);
          bus.grant <= 3'(3'b001 << pick);
          bus.sel   <= pick;
          bus.busy  <= 1'b1;
        end else begin
          state     <= IDLE;
          count     <= '0;
          bus.grant <= 3'b000;
          bus.sel   <= 2'b11;
          bus.busy  <= 1'b0;
        end
      end else if (count != CNT_SAT) begin
        count <= count + 1'b1;
      end
    end
  end

  grant_sel_consistent: assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.grant) && (bus.busy == (|bus.grant)) &&
    ((bus.sel == 2'b11) ? (bus.grant == 3'b000) : (bus.grant == 3'(3'b001 << bus.sel))));
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter: hand-derived expected outputs are queued per driven cycle.
module tb_rr_bus_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rr_bus_arbiter_if bus();

  rr_bus_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] grant;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    case (g)
      3'b001:  return 2'b00;
      3'b010:  return 2'b01;
      3'b100:  return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Drive one cycle of inputs, queue what the outputs must be after the edge, then pop and compare.
  task automatic step(input string tag, input logic [2:0] r, input logic rs,
                      input logic [2:0] g, input logic t);
    exp_t e;
    @(negedge clk);
    reset   = rs;
    bus.req = r;
    e.grant   = g;
    e.timeout = t;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "/queue"}, 4'h0, 4'h1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/grant"},   {1'b0, bus.grant},   {1'b0, e.grant});
      chk({tag, "/sel"},     {2'b0, bus.sel},     {2'b0, sel_of(e.grant)});
      chk({tag, "/busy"},    {3'b0, bus.busy},    {3'b0, |e.grant});
      chk({tag, "/timeout"}, {3'b0, bus.timeout}, {3'b0, e.timeout});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset   = 1'b1;
    bus.req = 3'b000;

    // Reset then idle
    step("rst", 3'b000, 1'b1, 3'b000, 1'b0);
    step("rst", 3'b000, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) step("idle", 3'b000, 1'b0, 3'b000, 1'b0);

    // Single short request from A
    step("short", 3'b001, 1'b0, 3'b001, 1'b0);
    step("short", 3'b001, 1'b0, 3'b001, 1'b0);
    step("short", 3'b000, 1'b0, 3'b000, 1'b0);

    // All three requesting: 4-cycle tenures rotating A->B->C->A, timeout on each handoff
    step("rot_rst", 3'b000, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 14; i++)
      step("rotate", 3'b111, 1'b0, 3'(3'b001 << ((i / 4) % 3)), (i % 4 == 0) && (i > 0));
    step("rot_end", 3'b000, 1'b0, 3'b000, 1'b0);

    // Lone hog B: re-granted after each forced release
    for (int i = 1; i <= 10; i++)
      step("hog", 3'b010, 1'b0, 3'b010, (i == 5) || (i == 9));
    step("hog_end", 3'b000, 1'b0, 3'b000, 1'b0);

    // Voluntary handoff A->B with no idle cycle
    step("vol", 3'b001, 1'b0, 3'b001, 1'b0);
    step("vol", 3'b011, 1'b0, 3'b001, 1'b0);
    step("vol", 3'b011, 1'b0, 3'b001, 1'b0);
    step("vol", 3'b010, 1'b0, 3'b010, 1'b0);
    step("vol", 3'b010, 1'b0, 3'b010, 1'b0);
    step("vol_end", 3'b000, 1'b0, 3'b000, 1'b0);

    // A request dropped before it could be granted is skipped
    step("skip", 3'b101, 1'b0, 3'b100, 1'b0);
    step("skip", 3'b100, 1'b0, 3'b100, 1'b0);
    step("skip", 3'b000, 1'b0, 3'b000, 1'b0);

    // Reset while C owns at count 3, then pointer restored so A wins first
    step("midrst", 3'b100, 1'b0, 3'b100, 1'b0);
    step("midrst", 3'b100, 1'b0, 3'b100, 1'b0);
    step("midrst", 3'b100, 1'b0, 3'b100, 1'b0);
    step("midrst", 3'b100, 1'b1, 3'b000, 1'b0);
    step("post_rst", 3'b111, 1'b0, 3'b001, 1'b0);
    step("post_rst", 3'b000, 1'b0, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
